// File: rtl/datapath_mc_if.sv
// Memory port bundle for datapath_mc: request/ack handshake plus address and data buses.
interface datapath_mc_if #(
  parameter int NBIT = 16
);
  logic            mem_req;
  logic            mem_we;
  logic            mem_ack;
  logic [NBIT-1:0] mem_rdata;
  logic [NBIT-1:0] BusA;
  logic [NBIT-1:0] DataOut;

  modport master (
    output mem_req, mem_we, BusA, DataOut,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, BusA, DataOut,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/datapath_mc.sv
// Multi-cycle datapath: register file, Mano-style function unit with registered flags,
// and a req/ack memory port with a wait-state timeout. One microoperation per start pulse.
module datapath_mc #(
  parameter int NBIT    = 16,
  parameter int RAW     = 4,
  parameter int TIMEOUT = 15
) (
  input  logic            clk_main,
  input  logic            reset,
  input  logic            start,
  input  logic [RAW-1:0]  DA,
  input  logic [RAW-1:0]  AA,
  input  logic [RAW-1:0]  BA,
  input  logic [3:0]      FS,
  input  logic            MB,
  input  logic            MD,
  input  logic            MW,
  input  logic            RW,
  input  logic [NBIT-1:0] const_in,
  datapath_mc_if.master   mem,
  output logic            V,
  output logic            C,
  output logic            N,
  output logic            Z,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, MEM_WAIT} state_t;

  state_t state, state_nxt;

  logic [NBIT-1:0]  rf [2**RAW];
  logic [RAW-1:0]   da_p0, aa_p0, ba_p0;
  logic [3:0]       fs_p0;
  logic             mb_p0, md_p0, mw_p0, rw_p0;
  logic [NBIT-1:0]  k_p0;
  logic [CNT_W-1:0] wait_cnt;
  logic [NBIT-1:0]  a_op, b_op, alu_f;
  logic             alu_v, alu_c, is_mem, wait_expired;

  // Returns {V, C, F}; arithmetic codes add A, a selected B-term and a carry-in.
  function automatic logic [NBIT+1:0] fu(input logic [3:0] fs,
                                         input logic [NBIT-1:0] a,
                                         input logic [NBIT-1:0] b);
    logic [NBIT-1:0]        y;
    logic                   cin;
    logic signed [NBIT:0]   ssum;
    logic [NBIT:0]          usum;
    logic [NBIT-1:0]        f;
    logic                   v, c;
    y    = '0;
    cin  = 1'b0;
    f    = '0;
    v    = 1'b0;
    c    = 1'b0;
    if (!fs[3]) begin
      if (fs[2:0] != 3'b111) begin
        unique case (fs[2:1])
          2'b00:   y = '0;
          2'b01:   y = b;
          2'b10:   y = ~b;
          default: y = '1;
        endcase
        cin = fs[0];
      end
      usum = {1'b0, a} + {1'b0, y} + {{NBIT{1'b0}}, cin};
      ssum = $signed({a[NBIT-1], a}) + $signed({y[NBIT-1], y}) + $signed({{NBIT{1'b0}}, cin});
      f    = usum[NBIT-1:0];
      c    = usum[NBIT];
      v    = ssum[NBIT] ^ ssum[NBIT-1];
    end else begin
      unique case (fs[2:0])
        3'b000:  f = a & b;
        3'b001:  f = a | b;
        3'b010:  f = a ^ b;
        3'b011:  f = ~a;
        3'b101:  f = b >> 1;
        3'b110:  f = b << 1;
        default: f = b;
      endcase
    end
    return {v, c, f};
  endfunction

  always_comb begin
    a_op         = rf[aa_p0];
    b_op         = mb_p0 ? k_p0 : rf[ba_p0];
    is_mem       = mw_p0 | md_p0;
    wait_expired = (wait_cnt == CNT_W'(TIMEOUT - 1));
    {alu_v, alu_c, alu_f} = fu(fs_p0, a_op, b_op);
  end

  always_ff @(posedge clk_main) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    unique case (state)
      IDLE:     if (start) state_nxt = EXEC;
      EXEC: begin
        busy      = 1'b1;
        state_nxt = is_mem ? MEM_WAIT : IDLE;
      end
      MEM_WAIT: begin
        busy = 1'b1;
        if (mem.mem_ack || wait_expired) state_nxt = IDLE;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      for (int i = 0; i < 2**RAW; i++) rf[i] <= '0;
      {da_p0, aa_p0, ba_p0} <= '0;
      fs_p0       <= '0;
      {mb_p0, md_p0, mw_p0, rw_p0} <= '0;
      k_p0        <= '0;
      wait_cnt    <= '0;
      mem.mem_req <= 1'b0;
      mem.mem_we  <= 1'b0;
      mem.BusA    <= '0;
      mem.DataOut <= '0;
      {V, C, N, Z} <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        // Operand capture
        IDLE: if (start) begin
          da_p0 <= DA;
          aa_p0 <= AA;
          ba_p0 <= BA;
          fs_p0 <= FS;
          mb_p0 <= MB;
          md_p0 <= MD;
          mw_p0 <= MW;
          rw_p0 <= RW;
          k_p0  <= const_in;
          err   <= 1'b0;
        end
        // Execute: flags and buses update for every op, memory ops included
        EXEC: begin
          mem.BusA    <= a_op;
          mem.DataOut <= b_op;
          V           <= alu_v;
          C           <= alu_c;
          N           <= alu_f[NBIT-1];
          Z           <= (alu_f == '0);
          wait_cnt    <= '0;
          if (is_mem) begin
            mem.mem_req <= 1'b1;
            mem.mem_we  <= mw_p0;
          end else begin
            done <= 1'b1;
            if (rw_p0) rf[da_p0] <= alu_f;
          end
        end
        // Memory wait: ack wins over a simultaneous timeout
        MEM_WAIT: begin
          if (mem.mem_ack) begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            done        <= 1'b1;
            if (md_p0 && rw_p0 && !mw_p0) rf[da_p0] <= mem.mem_rdata;
          end else if (wait_expired) begin
            mem.mem_req <= 1'b0;
            mem.mem_we  <= 1'b0;
            done        <= 1'b1;
            err         <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_mc.sv
// Bench for datapath_mc: directed scenarios plus randomized ops against an arithmetic
// reference model of the register file and function unit.
module tb_datapath_mc;
  localparam int NBIT = 16;
  localparam int RAW = 4;
  localparam int TIMEOUT = 15;

  logic        clk_main = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  DA = '0, AA = '0, BA = '0, FS = '0;
  logic        MB = 1'b0, MD = 1'b0, MW = 1'b0, RW = 1'b0;
  logic [15:0] const_in = '0;
  logic        V, C, N, Z, busy, done, err;

  datapath_mc_if #(.NBIT(NBIT)) mem ();

  datapath_mc #(.NBIT(NBIT), .RAW(RAW), .TIMEOUT(TIMEOUT)) dut (
    .clk_main(clk_main), .reset(reset), .start(start),
    .DA(DA), .AA(AA), .BA(BA), .FS(FS), .MB(MB), .MD(MD), .MW(MW), .RW(RW),
    .const_in(const_in), .mem(mem),
    .V(V), .C(C), .N(N), .Z(Z), .busy(busy), .done(done), .err(err)
  );

  always #5 clk_main = ~clk_main;

  int          checks = 0;
  int          errors = 0;
  int          ob_lat, ob_req;
  logic        ob_we, ob_err;
  logic [3:0]  ob_flags;
  logic [15:0] ob_busa, ob_dout;
  logic [15:0] mdl [16];

  // Reference function unit: true unsigned sum for carry, true signed sum for overflow.
  function automatic void model_fu(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                                   output logic [15:0] f, output logic [3:0] flags);
    int ua, ub, sa, sb, r, s;
    logic v, c;
    ua = int'(a);
    ub = int'(b);
    sa = a[15] ? ua - 65536 : ua;
    sb = b[15] ? ub - 65536 : ub;
    r = 0; s = 0; v = 1'b0; c = 1'b0;
    if (fs < 4'd8) begin
      case (fs)
        4'd1: begin r = ua + 1;             s = sa + 1;      end
        4'd2: begin r = ua + ub;            s = sa + sb;     end
        4'd3: begin r = ua + ub + 1;        s = sa + sb + 1; end
        4'd4: begin r = ua + 65535 - ub;    s = sa - sb - 1; end
        4'd5: begin r = ua + 65536 - ub;    s = sa - sb;     end
        4'd6: begin r = ua + 65535;         s = sa - 1;      end
        default: begin r = ua;              s = sa;          end
      endcase
      f = r[15:0];
      c = r[16];
      v = (s > 32767) || (s < -32768);
    end else begin
      case (fs)
        4'd8:  f = a & b;
        4'd9:  f = a | b;
        4'd10: f = a ^ b;
        4'd11: f = ~a;
        4'd13: f = {1'b0, b[15:1]};
        4'd14: f = {b[14:0], 1'b0};
        default: f = b;
      endcase
    end
    flags = {v, c, f[15], f == 16'h0};
  endfunction

  task automatic do_reset();
    @(negedge clk_main);
    reset = 1'b1; start = 1'b0; mem.mem_ack = 1'b0;
    repeat (2) @(negedge clk_main);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0;
  endtask

  // Drives one op starting at a negedge in IDLE; records what was seen up to done (bounded).
  task automatic issue(input logic [3:0] fs, input logic [3:0] da, input logic [3:0] aa,
                       input logic [3:0] ba, input logic mb, input logic md, input logic mw,
                       input logic rw, input logic [15:0] k, input int ack_n,
                       input logic [15:0] rdata, input bit start_mid);
    int cyc;
    FS = fs; DA = da; AA = aa; BA = ba; MB = mb; MD = md; MW = mw; RW = rw;
    const_in = k; mem.mem_rdata = rdata; start = 1'b1;
    ob_lat = -1; ob_req = 0; ob_we = 1'b0; ob_err = 1'bx;
    @(negedge clk_main);
    start = 1'b0;
    cyc = 1;
    while (cyc < 60) begin
      @(negedge clk_main);
      cyc++;
      mem.mem_ack = 1'b0;
      start = start_mid && (cyc == 2);
      if (mem.mem_req) begin
        ob_req++;
        if (ob_req == 1) ob_we = mem.mem_we;
      end
      if (done) begin
        ob_lat = cyc; ob_flags = {V, C, N, Z};
        ob_busa = mem.BusA; ob_dout = mem.DataOut; ob_err = err;
        break;
      end
      if (ack_n > 0 && cyc == 1 + ack_n) mem.mem_ack = 1'b1;
    end
    start = 1'b0;
    mem.mem_ack = 1'b0;
  endtask

  task automatic peek(input logic [3:0] r, output logic [15:0] val);
    issue(4'h0, 4'h0, r, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 0, 16'h0, 1'b0);
    val = (ob_lat == 2) ? ob_busa : 16'hxxxx;
  endtask

  task automatic test_reset();
    logic [15:0] val;
    reset = 1'b1;
    repeat (3) @(negedge clk_main);
    checks++;
    if ({mem.mem_req, mem.mem_we, busy, done, err, V, C, N, Z} !== 9'h0 ||
        mem.BusA !== 16'h0 || mem.DataOut !== 16'h0) begin
      errors++;
      $display("FAIL reset_outputs got req/we/busy/done/err/VCNZ=%b BusA=%h DataOut=%h want all 0",
               {mem.mem_req, mem.mem_we, busy, done, err, V, C, N, Z}, mem.BusA, mem.DataOut);
    end
    reset = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0;
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), val);
      checks++;
      if (val !== 16'h0) begin
        errors++;
        $display("FAIL reset_reg R%0d got %h want 0000", i, val);
      end
    end
  endtask

  task automatic test_const_inc();
    logic [15:0] val;
    issue(4'hC, 4'd1, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h7FFF, 0, 16'h0, 1'b0);
    checks++;
    if (ob_lat !== 2) begin errors++; $display("FAIL const_latency got %0d want 2", ob_lat); end
    issue(4'h1, 4'd2, 4'd1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b0);
    checks++;
    if (ob_lat !== 2) begin errors++; $display("FAIL inc_latency got %0d want 2", ob_lat); end
    checks++;
    if (ob_flags !== 4'b1010) begin errors++; $display("FAIL inc_flags VCNZ got %b want 1010", ob_flags); end
    peek(4'd2, val);
    checks++;
    if (val !== 16'h8000) begin errors++; $display("FAIL inc_result R2 got %h want 8000", val); end
  endtask

  task automatic test_sub_zero();
    logic [15:0] val;
    issue(4'hC, 4'd3, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 0, 16'h0, 1'b0);
    issue(4'hC, 4'd4, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h1234, 0, 16'h0, 1'b0);
    issue(4'h5, 4'd5, 4'd3, 4'd4, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 0, 16'h0, 1'b0);
    checks++;
    if (ob_flags !== 4'b0101) begin errors++; $display("FAIL sub_flags VCNZ got %b want 0101", ob_flags); end
    peek(4'd5, val);
    checks++;
    if (val !== 16'h0) begin errors++; $display("FAIL sub_result R5 got %h want 0000", val); end
  endtask

  task automatic test_store_load();
    logic [15:0] val;
    issue(4'hC, 4'd7, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0010, 0, 16'h0, 1'b0);
    issue(4'hC, 4'd8, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'hBEEF, 0, 16'h0, 1'b0);
    // store with RW=1 toward R9 must leave R9 alone
    issue(4'h0, 4'd9, 4'd7, 4'd8, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0, 3, 16'h0, 1'b0);
    checks++;
    if (ob_we !== 1'b1 || ob_busa !== 16'h0010 || ob_dout !== 16'hBEEF) begin
      errors++;
      $display("FAIL store_bus got we=%b BusA=%h DataOut=%h want we=1 BusA=0010 DataOut=beef",
               ob_we, ob_busa, ob_dout);
    end
    checks++;
    if (ob_lat !== 5 || ob_req !== 3) begin
      errors++; $display("FAIL store_timing got lat=%0d req=%0d want lat=5 req=3", ob_lat, ob_req);
    end
    peek(4'd9, val);
    checks++;
    if (val !== 16'h0) begin errors++; $display("FAIL store_no_wb R9 got %h want 0000", val); end
    issue(4'h0, 4'd6, 4'd7, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 1, 16'hBEEF, 1'b0);
    checks++;
    if (ob_lat !== 3 || ob_we !== 1'b0) begin
      errors++; $display("FAIL load_timing got lat=%0d we=%b want lat=3 we=0", ob_lat, ob_we);
    end
    peek(4'd6, val);
    checks++;
    if (val !== 16'hBEEF) begin errors++; $display("FAIL load_result R6 got %h want beef", val); end
  endtask

  task automatic test_timeout();
    logic [15:0] val;
    issue(4'hC, 4'd9, 4'd0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5555, 0, 16'h0, 1'b0);
    issue(4'h0, 4'd9, 4'd7, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 0, 16'hAAAA, 1'b0);
    checks++;
    if (ob_req !== TIMEOUT || ob_lat !== TIMEOUT + 2 || ob_err !== 1'b1) begin
      errors++;
      $display("FAIL timeout got req=%0d lat=%0d err=%b want req=%0d lat=%0d err=1",
               ob_req, ob_lat, ob_err, TIMEOUT, TIMEOUT + 2);
    end
    peek(4'd9, val);
    checks++;
    if (val !== 16'h5555 || ob_err !== 1'b0) begin
      errors++; $display("FAIL timeout_no_wb got R9=%h err=%b want R9=5555 err=0", val, ob_err);
    end
    // ack on the final wait cycle is a success
    issue(4'h0, 4'd9, 4'd7, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, TIMEOUT, 16'h1111, 1'b0);
    checks++;
    if (ob_err !== 1'b0 || ob_lat !== TIMEOUT + 2 || ob_req !== TIMEOUT) begin
      errors++;
      $display("FAIL late_ack got err=%b lat=%0d req=%0d want err=0 lat=%0d req=%0d",
               ob_err, ob_lat, ob_req, TIMEOUT + 2, TIMEOUT);
    end
    peek(4'd9, val);
    checks++;
    if (val !== 16'h1111) begin errors++; $display("FAIL late_ack_wb R9 got %h want 1111", val); end
  endtask

  task automatic test_ignored();
    logic [15:0] val;
    int extra;
    issue(4'h0, 4'd10, 4'd7, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0, 3, 16'h4321, 1'b1);
    extra = 0;
    repeat (4) begin
      @(negedge clk_main);
      if (done || busy) extra++;
    end
    checks++;
    if (ob_lat !== 5 || extra !== 0) begin
      errors++; $display("FAIL start_in_wait got lat=%0d extra=%0d want lat=5 extra=0", ob_lat, extra);
    end
    DA = 4'd10; MD = 1'b1; RW = 1'b1; mem.mem_rdata = 16'hDEAD;
    mem.mem_ack = 1'b1;
    extra = 0;
    repeat (3) begin
      @(negedge clk_main);
      if (done || busy || mem.mem_req) extra++;
    end
    mem.mem_ack = 1'b0;
    peek(4'd10, val);
    checks++;
    if (val !== 16'h4321 || extra !== 0) begin
      errors++; $display("FAIL ack_in_idle got R10=%h activity=%0d want R10=4321 activity=0", val, extra);
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] val;
    int seen;
    FS = 4'h0; DA = 4'd11; AA = 4'd7; MB = 1'b0; MD = 1'b1; MW = 1'b0; RW = 1'b1;
    mem.mem_rdata = 16'h7777; start = 1'b1;
    @(negedge clk_main); start = 1'b0;
    @(negedge clk_main);
    checks++;
    if (mem.mem_req !== 1'b1) begin errors++; $display("FAIL midrst_req_before got %b want 1", mem.mem_req); end
    reset = 1'b1;
    @(negedge clk_main);
    checks++;
    if (mem.mem_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL midrst_req_after got req=%b busy=%b want 0 0", mem.mem_req, busy);
    end
    reset = 1'b0; mem.mem_ack = 1'b1;
    seen = 0;
    repeat (4) begin
      @(negedge clk_main);
      mem.mem_ack = 1'b0;
      if (done || mem.mem_req) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL midrst_done got %0d pulses want 0", seen); end
    for (int i = 0; i < 16; i++) mdl[i] = 16'h0;
    for (int i = 6; i < 12; i++) begin
      peek(4'(i), val);
      checks++;
      if (val !== 16'h0) begin errors++; $display("FAIL midrst_reg R%0d got %h want 0000", i, val); end
    end
  endtask

  task automatic test_random();
    logic [3:0]  fs, da, aa, ba, eflags;
    logic        mb, md, mw, rw;
    logic [15:0] k, rd, a, b, f, val;
    int          kind, ackn, elat, ereq;
    for (int n = 0; n < 60; n++) begin
      fs = 4'($urandom_range(0, 15)); da = 4'($urandom_range(0, 15));
      aa = 4'($urandom_range(0, 15)); ba = 4'($urandom_range(0, 15));
      mb = 1'($urandom_range(0, 1)); rw = 1'($urandom_range(0, 1));
      k = 16'($urandom); rd = 16'($urandom);
      kind = $urandom_range(0, 3);
      md = (kind == 2) ? 1'b1 : (kind == 3) ? 1'($urandom_range(0, 1)) : 1'b0;
      mw = (kind == 3);
      if (n < 8) rw = 1'b1;
      ackn = (md || mw) ? $urandom_range(1, 4) : 0;
      a = mdl[aa];
      b = mb ? k : mdl[ba];
      model_fu(fs, a, b, f, eflags);
      issue(fs, da, aa, ba, mb, md, mw, rw, k, ackn, rd, 1'b0);
      elat = 2 + ackn;
      ereq = ackn;
      checks++;
      if (ob_lat !== elat || ob_req !== ereq || ob_we !== mw) begin
        errors++;
        $display("FAIL rand_timing op%0d got lat=%0d req=%0d we=%b want lat=%0d req=%0d we=%b",
                 n, ob_lat, ob_req, ob_we, elat, ereq, mw);
      end
      checks++;
      if (ob_flags !== eflags) begin
        errors++; $display("FAIL rand_flags op%0d fs=%h a=%h b=%h got VCNZ=%b want %b", n, fs, a, b, ob_flags, eflags);
      end
      checks++;
      if (ob_busa !== a || ob_dout !== b) begin
        errors++; $display("FAIL rand_bus op%0d got BusA=%h DataOut=%h want %h %h", n, ob_busa, ob_dout, a, b);
      end
      if (!md && !mw && rw) mdl[da] = f;
      else if (md && !mw && rw) mdl[da] = rd;
    end
    for (int i = 0; i < 16; i++) begin
      peek(4'(i), val);
      checks++;
      if (val !== mdl[i]) begin errors++; $display("FAIL rand_reg R%0d got %h want %h", i, val, mdl[i]); end
    end
  endtask

  initial begin
    mem.mem_ack = 1'b0;
    mem.mem_rdata = 16'h0;
    test_reset();
    test_const_inc();
    test_sub_zero();
    test_store_load();
    test_timeout();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
